sequence_player: RTL and testbench

SEQUENCE_PLAYER -- requirements
Module: sequence_player

---
 rtl/sequence_player.sv | 119 +++++++++++
 tb/tb_sequence_player.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_player.sv
// Plays a stored button sequence on four one-hot LEDs, one entry per ON/OFF period.
// Latency: first LED lit the cycle after start; each entry occupies ON_CYCLES+OFF_CYCLES cycles.
// Backpressure: none; start is ignored while busy, abort/reset cancel playback at once.
module sequence_player #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0][2:0] segment,
  input  logic [4:0]      round,
  input  logic            start,
  input  logic            abort,
  output logic [3:0]      leds,
  output logic [4:0]      play_idx,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, ON, OFF, FIN} state_t;

  localparam logic [25:0] ON_LAST  = 26'(ON_CYCLES - 1);
  localparam logic [25:0] OFF_LAST = 26'(OFF_CYCLES - 1);

  state_t      state;
  logic [25:0] cnt;
  logic [4:0]  nxt_idx;
  logic        last_entry;

  // Map a 2-bit button code onto its LED; empty entries never reach here.
  function automatic logic [3:0] decode(input logic [2:0] code);
    logic [3:0] v;
    v = 4'b0000;
    if (!code[2]) begin
      case (code[1:0])
        2'b11:   v = 4'b1000;
        2'b10:   v = 4'b0100;
        2'b01:   v = 4'b0010;
        default: v = 4'b0001;
      endcase
    end
    return v;
  endfunction

  // Decide whether the entry just shown is the final one (round reached, index 31, or next entry empty).
  always_comb begin
    nxt_idx    = play_idx + 5'd1;
    last_entry = (play_idx == round) || (play_idx == 5'd31) || segment[nxt_idx][2];
  end

  // Playback FSM with dwell counter; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      leds     <= 4'b0000;
      play_idx <= 5'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
      leds  <= 4'b0000;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            play_idx <= 5'd0;
            cnt      <= '0;
            busy     <= 1'b1;
            if (!segment[0][2]) begin
              state <= ON;
              leds  <= decode(segment[0]);
            end else begin
              state <= FIN;
              leds  <= 4'b0000;
              done  <= 1'b1;
            end
          end
        end
        ON: begin
          if (cnt == ON_LAST) begin
            state <= OFF;
            leds  <= 4'b0000;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        OFF: begin
          if (cnt == OFF_LAST) begin
            cnt <= '0;
            if (last_entry) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= ON;
              play_idx <= nxt_idx;
              leds     <= decode(segment[nxt_idx]);
            end
          end else begin
            cnt <= cnt + 26'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          leds  <= 4'b0000;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// Scoreboard bench for sequence_player with short ON/OFF times.
// Stimulus pushes expected LED/done events; a negedge monitor pops and compares them.
// Randomized sequences are checked against a simple playback model.
module tb_sequence_player;

  localparam int ONC  = 4;
  localparam int OFFC = 2;
  localparam int PER  = ONC + OFFC;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0][2:0] segment = '0;
  logic [4:0]       round = 5'd0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [3:0]       leds;
  logic [4:0]       play_idx;
  logic             busy;
  logic             done;

  sequence_player #(.ON_CYCLES(ONC), .OFF_CYCLES(OFFC)) dut (
    .clk(clk), .reset(reset), .segment(segment), .round(round),
    .start(start), .abort(abort), .leds(leds), .play_idx(play_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       kind;   // 0 = LED lit, 1 = LED went dark, 2 = done pulse
    logic [3:0] led;
    int       idx;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  passed = 0;
  int  mcyc = 0;
  int  busy_cycles = 0;
  bit  prev_lit = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, mcyc);
  endtask

  task automatic push_ev(input int kind, input logic [3:0] led, input int idx, input int cyc);
    ev_t e;
    e.kind = kind; e.led = led; e.idx = idx; e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // Reference: list the entries that should play and when, from the sequence rules.
  task automatic model_push(input logic [31:0][2:0] sg, input int rnd, input int base,
                            output int last_idx, output int nplayed);
    int i;
    int n;
    logic [2:0] c;
    n = 0;
    i = 0;
    if (sg[0][2] == 1'b0) begin
      while (1) begin
        c = sg[i];
        push_ev(0, 4'b0001 << c[1:0], i, base + 2 + PER * n);
        push_ev(1, 4'b0000, 0, base + 2 + PER * n + ONC);
        n++;
        if (i == rnd || i == 31) break;
        c = sg[i + 1];
        if (c[2]) break;
        i++;
      end
    end
    push_ev(2, 4'b0000, 0, base + 2 + PER * n);
    last_idx = i;
    nplayed = n;
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", kind, -1);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", mcyc, e.cyc);
      if (kind == 0) begin
        check("lit_leds", int'(leds), int'(e.led));
        check("lit_idx", int'(play_idx), e.idx);
        check("lit_busy", int'(busy), 1);
      end
    end
  endtask

  // Monitor: sample on falling edge, turn output changes into events.
  always @(negedge clk) begin
    bit lit;
    mcyc++;
    if (busy === 1'b1) busy_cycles++;
    lit = (leds !== 4'b0000) && !$isunknown(leds);
    if (lit && !prev_lit) handle(0);
    if (!lit && prev_lit) handle(1);
    if (done === 1'b1) handle(2);
    prev_lit = lit;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 600) begin
      step();
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run_play(input logic [31:0][2:0] sg, input int rnd, input bit repulse,
                          input int exp_busy);
    int base;
    int last_idx;
    int n;
    int b0;
    segment = sg;
    round = 5'(rnd);
    step();
    base = mcyc;
    b0 = busy_cycles;
    model_push(sg, rnd, base, last_idx, n);
    start = 1'b1;
    step();
    start = 1'b0;
    if (repulse && n > 0) begin
      step();
      start = 1'b1;
      segment[0] = 3'($urandom_range(0, 7));
      step();
      start = 1'b0;
    end
    drain();
    @(negedge clk);
    #1;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("final_idx", int'(play_idx), last_idx);
    check("busy_len", busy_cycles - b0, (exp_busy >= 0) ? exp_busy : (PER * n + 1));
  endtask

  task automatic run_cancel(input bit use_reset);
    logic [31:0][2:0] sg;
    int base;
    int t;
    for (int k = 0; k < 32; k++) sg[k] = 3'($urandom_range(0, 3));
    segment = sg;
    round = 5'd5;
    step();
    base = mcyc;
    push_ev(0, 4'b0001 << sg[0][1:0], 0, base + 2);
    push_ev(1, 4'b0000, 0, base + 2 + ONC);
    push_ev(0, 4'b0001 << sg[1][1:0], 1, base + 2 + PER);
    push_ev(1, 4'b0000, 0, base + 2 + PER + 2);
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (mcyc < base + 2 + PER && t < 100) begin
      step();
      t++;
    end
    if (use_reset) reset = 1'b1;
    else abort = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    drain();
    @(negedge clk);
    #1;
    check("cancel_busy", int'(busy), 0);
    check("cancel_leds", int'(leds), 0);
    check("cancel_idx", int'(play_idx), use_reset ? 0 : 1);
    repeat (12) step();
  endtask

  initial begin
    logic [31:0][2:0] sg;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_leds", int'(leds), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(play_idx), 0);

    // Three-entry sequence, round 2.
    sg = '0;
    sg[0] = 3'b011; sg[1] = 3'b000; sg[2] = 3'b010;
    run_play(sg, 2, 1'b0, 19);

    // Empty first entry: straight to done.
    sg[0] = 3'b100;
    run_play(sg, 2, 1'b0, 1);

    // Empty entry 2 stops playback before round 5.
    for (int k = 0; k < 32; k++) sg[k] = 3'($urandom_range(0, 3));
    sg[2] = 3'b101;
    run_play(sg, 5, 1'b0, -1);

    // All 32 entries valid, round 31.
    for (int k = 0; k < 32; k++) sg[k] = 3'($urandom_range(0, 3));
    run_play(sg, 31, 1'b0, 32 * PER + 1);

    // Cancel mid-playback by abort, then by reset; playback afterwards restarts from 0.
    run_cancel(1'b0);
    for (int k = 0; k < 32; k++) sg[k] = 3'($urandom_range(0, 3));
    run_play(sg, 3, 1'b0, -1);
    run_cancel(1'b1);
    run_play(sg, 1, 1'b0, -1);

    // Start re-pulsed while busy with entry 0 rewritten mid-ON.
    run_play(sg, 2, 1'b1, -1);

    // Randomized sequences with occasional empty entries.
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 32; k++)
        sg[k] = ($urandom_range(0, 9) == 0) ? 3'b100 | 3'($urandom_range(0, 3))
                                             : 3'($urandom_range(0, 3));
      run_play(sg, $urandom_range(0, 31), r[0], -1);
    end

    repeat (5) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
